attention_kv_streamer: RTL and testbench

- Upstream feeder for the memory attention pipeline stage.
- Holds a bank of key/value memory slots and latches one query per request.
- On a start command, streams (query, key, value) triples over a contiguous slot range, one per cycle, into the 3-stage attention stage.
- Tracks pipeline latency so results leaving the attention stage are tagged with valid, slot index and last flags.

---
 rtl/memory_attention_pkg.sv | 22 ++
 rtl/kv_slot_ram.sv | 40 ++++
 rtl/attention_kv_streamer.sv | 153 +++++++++++++++
 tb/tb_attention_kv_streamer.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/memory_attention_pkg.sv
// Shared constants and types for the memory attention feeder: stream FSM states
// and the result tag carried alongside the attention-stage latency.
package memory_attention_pkg;

   localparam int DATA_W    = 32;
   localparam int PIPE_LAT  = 3;
   localparam int KV_DEPTH  = 64;
   localparam int KV_ADDR_W = $clog2(KV_DEPTH);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      DRAIN = 2'd2
   } stream_state_t;

   typedef struct packed {
      logic                 valid;
      logic [KV_ADDR_W-1:0] index;
      logic                 last;
   } result_tag_t;

endpackage

// File: rtl/kv_slot_ram.sv
// Key/value slot storage: one write port, one read port, read-first on a same-slot
// collision, registered read data with a resettable output register.
module kv_slot_ram
   import memory_attention_pkg::*;
#(
   parameter int WIDTH  = 2 * memory_attention_pkg::DATA_W,
   parameter int DEPTH  = KV_DEPTH,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [WIDTH-1:0]  wr_data,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [WIDTH-1:0]  rd_data
);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [WIDTH-1:0] r_rd_data;

   always_ff @(posedge clk) begin
      if (wr_en) begin
         r_mem[wr_addr] <= wr_data;
      end
   end

   // Reading the array with a non-blocking write pending yields the old word.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rd_data <= '0;
      end else if (rd_en) begin
         r_rd_data <= r_mem[rd_addr];
      end
   end

   assign rd_data = r_rd_data;

endmodule

// File: rtl/attention_kv_streamer.sv
// Streams (query, key, value) triples over a contiguous slot range into the
// attention stage and tags the results that emerge PIPE_LAT cycles later.
module attention_kv_streamer
   import memory_attention_pkg::*;
#(
   parameter int DATA_W   = memory_attention_pkg::DATA_W,
   parameter int DEPTH    = KV_DEPTH,
   parameter int ADDR_W   = $clog2(DEPTH),
   parameter int PIPE_LAT = memory_attention_pkg::PIPE_LAT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_key,
   input  logic [DATA_W-1:0] wr_value,
   input  logic              start,
   input  logic [DATA_W-1:0] start_query,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W:0]   count,
   input  logic              pause,
   output logic              busy,
   output logic [DATA_W-1:0] query,
   output logic [DATA_W-1:0] key,
   output logic [DATA_W-1:0] value,
   output logic              qkv_valid,
   output logic              result_valid,
   output logic [ADDR_W-1:0] result_index,
   output logic              result_last,
   output logic              done,
   output logic [1:0]        dbg_state
);

   localparam logic [ADDR_W:0]   C_ONE = {{ADDR_W{1'b0}}, 1'b1};
   localparam logic [ADDR_W-1:0] A_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

   stream_state_t     r_state;
   logic [DATA_W-1:0] r_query;
   logic [ADDR_W-1:0] r_rd_addr;
   logic [ADDR_W:0]   r_count;
   logic [ADDR_W:0]   r_issued;
   logic              r_req_valid;
   logic [ADDR_W-1:0] r_req_addr;
   logic              r_req_last;
   logic              r_qkv_valid;
   logic [ADDR_W-1:0] r_qkv_index;
   logic              r_qkv_last;
   logic              r_zero_done;
   result_tag_t       r_tag [PIPE_LAT];

   logic                w_issue_last;
   logic                w_tag_last;
   logic [2*DATA_W-1:0] w_rd_data;

   assign w_issue_last = (r_issued + C_ONE) == r_count;
   assign w_tag_last   = r_tag[PIPE_LAT-1].valid && r_tag[PIPE_LAT-1].last;

   kv_slot_ram #(
      .WIDTH  (2 * DATA_W),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_ram (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data ({wr_key, wr_value}),
      .rd_en   (r_req_valid),
      .rd_addr (r_req_addr),
      .rd_data (w_rd_data)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= IDLE;
         r_query     <= '0;
         r_rd_addr   <= '0;
         r_count     <= '0;
         r_issued    <= '0;
         r_req_valid <= 1'b0;
         r_req_addr  <= '0;
         r_req_last  <= 1'b0;
         r_qkv_valid <= 1'b0;
         r_qkv_index <= '0;
         r_qkv_last  <= 1'b0;
         r_zero_done <= 1'b0;
         for (int i = 0; i < PIPE_LAT; i++) begin
            r_tag[i] <= '0;
         end
      end else begin
         r_zero_done <= 1'b0;
         r_req_valid <= 1'b0;
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_query <= start_query;
                  if (count == '0) begin
                     r_zero_done <= 1'b1;
                  end else begin
                     r_rd_addr <= base_addr;
                     r_count   <= count;
                     r_issued  <= '0;
                     r_state   <= FETCH;
                  end
               end
            end
            FETCH: begin
               // The registered request feeds the RAM read port on the next edge.
               if (!pause) begin
                  r_req_valid <= 1'b1;
                  r_req_addr  <= r_rd_addr;
                  r_req_last  <= w_issue_last;
                  r_rd_addr   <= r_rd_addr + A_ONE;
                  r_issued    <= r_issued + C_ONE;
                  if (w_issue_last) begin
                     r_state <= DRAIN;
                  end
               end
            end
            DRAIN: begin
               if (w_tag_last) begin
                  r_state <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase

         r_qkv_valid <= r_req_valid;
         if (r_req_valid) begin
            r_qkv_index <= r_req_addr;
            r_qkv_last  <= r_req_last;
         end

         // Latency tracker mirrors the attention stage's output register timing.
         r_tag[0] <= '{valid: r_qkv_valid, index: r_qkv_index, last: r_qkv_valid & r_qkv_last};
         for (int i = 1; i < PIPE_LAT; i++) begin
            r_tag[i] <= r_tag[i-1];
         end
      end
   end

   assign busy         = (r_state != IDLE);
   assign query        = r_query;
   assign key          = w_rd_data[2*DATA_W-1:DATA_W];
   assign value        = w_rd_data[DATA_W-1:0];
   assign qkv_valid    = r_qkv_valid;
   assign result_valid = r_tag[PIPE_LAT-1].valid;
   assign result_index = r_tag[PIPE_LAT-1].index;
   assign result_last  = w_tag_last;
   assign done         = w_tag_last | r_zero_done;
   assign dbg_state    = r_state;

endmodule

// File: tb/tb_attention_kv_streamer.sv
// Directed bench for attention_kv_streamer: hand-computed triple, result and done
// timing per request, collision, wrap, pause and mid-request reset cases.
module tb_attention_kv_streamer;

   logic        clk = 1'b0;
   logic        rst;
   logic        wr_en;
   logic [5:0]  wr_addr;
   logic [31:0] wr_key;
   logic [31:0] wr_value;
   logic        start;
   logic [31:0] start_query;
   logic [5:0]  base_addr;
   logic [6:0]  count;
   logic        pause;
   logic        busy;
   logic [31:0] query;
   logic [31:0] key;
   logic [31:0] value;
   logic        qkv_valid;
   logic        result_valid;
   logic [5:0]  result_index;
   logic        result_last;
   logic        done;
   logic [1:0]  dbg_state;

   always #5 clk = ~clk;

   attention_kv_streamer dut (
      .clk          (clk),
      .rst          (rst),
      .wr_en        (wr_en),
      .wr_addr      (wr_addr),
      .wr_key       (wr_key),
      .wr_value     (wr_value),
      .start        (start),
      .start_query  (start_query),
      .base_addr    (base_addr),
      .count        (count),
      .pause        (pause),
      .busy         (busy),
      .query        (query),
      .key          (key),
      .value        (value),
      .qkv_valid    (qkv_valid),
      .result_valid (result_valid),
      .result_index (result_index),
      .result_last  (result_last),
      .done         (done),
      .dbg_state    (dbg_state)
   );

   int n_vec = 0;
   int n_err = 0;

   // Expected per-request behaviour, offsets counted from the cycle after the start edge.
   int          exp_qkv_off[$];
   logic [31:0] exp_q[$];
   logic [31:0] exp_val_q[$];
   int          exp_res_off[$];
   logic [31:0] exp_idx_q[$];
   int          exp_done_off;
   logic [31:0] exp_query;
   int          exp_busy;

   int          obs_qkv_off[$];
   logic [31:0] obs_key[$];
   logic [31:0] obs_val[$];
   logic [31:0] obs_query[$];
   int          obs_res_off[$];
   logic [31:0] obs_idx[$];
   logic        obs_last[$];
   int          obs_done_off[$];
   int          obs_busy;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic write_slot(input logic [5:0] a, input logic [31:0] k, input logic [31:0] v);
      wr_en = 1'b1; wr_addr = a; wr_key = k; wr_value = v;
      step();
      wr_en = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, ".busy"}, busy, 0);
      check({tag, ".query"}, query, 0);
      check({tag, ".key"}, key, 0);
      check({tag, ".value"}, value, 0);
      check({tag, ".qkv_valid"}, qkv_valid, 0);
      check({tag, ".result_valid"}, result_valid, 0);
      check({tag, ".result_index"}, result_index, 0);
      check({tag, ".result_last"}, result_last, 0);
      check({tag, ".done"}, done, 0);
      check({tag, ".state"}, dbg_state, 0);
   endtask

   // Issues one request, then records 40 cycles of outputs; optional pause mask,
   // one slot write and one extra start pulse at chosen offsets.
   task automatic run_req(input logic [31:0] q, input logic [5:0] base, input logic [6:0] cnt,
                          input logic [63:0] pmask, input int wr_off, input logic [5:0] wa,
                          input logic [31:0] wk, input logic [31:0] wv, input int rs_off);
      obs_qkv_off.delete(); obs_key.delete(); obs_val.delete(); obs_query.delete();
      obs_res_off.delete(); obs_idx.delete(); obs_last.delete(); obs_done_off.delete();
      obs_busy = 0;
      start = 1'b1; start_query = q; base_addr = base; count = cnt;
      step();
      start = 1'b0;
      start_query = $urandom;
      base_addr = 6'($urandom_range(0, 63));
      count = 7'($urandom_range(0, 64));
      for (int c = 0; c < 40; c++) begin
         if (qkv_valid) begin
            obs_qkv_off.push_back(c); obs_key.push_back(key);
            obs_val.push_back(value); obs_query.push_back(query);
         end
         if (result_valid) begin
            obs_res_off.push_back(c); obs_idx.push_back(32'(result_index));
            obs_last.push_back(result_last);
         end
         if (done) obs_done_off.push_back(c);
         if (busy) obs_busy++;
         pause = pmask[c];
         wr_en = (c == wr_off); wr_addr = wa; wr_key = wk; wr_value = wv;
         start = (c == rs_off);
         if (c == rs_off) begin
            start_query = 32'h55; base_addr = 6'd20; count = 7'd2;
         end
         step();
      end
      pause = 1'b0; wr_en = 1'b0; start = 1'b0;
   endtask

   task automatic verify(input string tag);
      check({tag, ".qkv_n"}, obs_qkv_off.size(), exp_qkv_off.size());
      for (int i = 0; i < exp_qkv_off.size() && i < obs_qkv_off.size(); i++) begin
         check($sformatf("%s.qkv_off%0d", tag, i), obs_qkv_off[i], exp_qkv_off[i]);
         check($sformatf("%s.key%0d", tag, i), obs_key[i], exp_q[i]);
         check($sformatf("%s.value%0d", tag, i), obs_val[i], exp_val_q[i]);
         check($sformatf("%s.query%0d", tag, i), obs_query[i], exp_query);
      end
      check({tag, ".res_n"}, obs_res_off.size(), exp_res_off.size());
      for (int i = 0; i < exp_res_off.size() && i < obs_res_off.size(); i++) begin
         check($sformatf("%s.res_off%0d", tag, i), obs_res_off[i], exp_res_off[i]);
         check($sformatf("%s.res_idx%0d", tag, i), obs_idx[i], exp_idx_q[i]);
         check($sformatf("%s.res_last%0d", tag, i), obs_last[i], (i == exp_res_off.size() - 1));
      end
      check({tag, ".done_n"}, obs_done_off.size(), 1);
      if (obs_done_off.size() > 0) check({tag, ".done_off"}, obs_done_off[0], exp_done_off);
      check({tag, ".busy_cycles"}, obs_busy, exp_busy);
   endtask

   initial begin
      int act;
      rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_key = '0; wr_value = '0;
      start = 1'b0; start_query = '0; base_addr = '0; count = '0; pause = 1'b0;
      step(); step();
      check_all_zero("reset");
      rst = 1'b0;
      step();
      check_all_zero("post_reset");

      for (int i = 0; i < 64; i++) write_slot(6'(i), 32'(i + 1), 32'(10 * (i + 1)));

      // Basic stream, with a start pulse mid-request that must be ignored.
      exp_qkv_off = '{2, 3, 4, 5}; exp_q = '{1, 2, 3, 4}; exp_val_q = '{10, 20, 30, 40};
      exp_res_off = '{5, 6, 7, 8}; exp_idx_q = '{0, 1, 2, 3};
      exp_done_off = 8; exp_query = 32'd2; exp_busy = 9;
      run_req(32'd2, 6'd0, 7'd4, 64'd0, -1, 6'd0, 0, 0, 3);
      verify("basic");

      exp_qkv_off = '{2, 3, 4, 5}; exp_q = '{63, 64, 1, 2}; exp_val_q = '{630, 640, 10, 20};
      exp_res_off = '{5, 6, 7, 8}; exp_idx_q = '{62, 63, 0, 1};
      exp_done_off = 8; exp_query = 32'hC0FFEE; exp_busy = 9;
      run_req(32'hC0FFEE, 6'd62, 7'd4, 64'd0, -1, 6'd0, 0, 0, -1);
      verify("wrap");

      exp_qkv_off = '{}; exp_q = '{}; exp_val_q = '{};
      exp_res_off = '{}; exp_idx_q = '{};
      exp_done_off = 0; exp_query = 32'd0; exp_busy = 0;
      run_req(32'd9, 6'd5, 7'd0, 64'd0, -1, 6'd0, 0, 0, -1);
      verify("zero");

      exp_qkv_off = '{2, 3, 6, 7, 8}; exp_q = '{11, 12, 13, 14, 15};
      exp_val_q = '{110, 120, 130, 140, 150};
      exp_res_off = '{5, 6, 9, 10, 11}; exp_idx_q = '{10, 11, 12, 13, 14};
      exp_done_off = 11; exp_query = 32'h1234; exp_busy = 12;
      run_req(32'h1234, 6'd10, 7'd5, 64'b1100, -1, 6'd0, 0, 0, -1);
      verify("pause");

      // Slot 2 is read by the RAM on the edge closing offset 3.
      exp_qkv_off = '{2, 3, 4, 5}; exp_q = '{1, 2, 3, 4}; exp_val_q = '{10, 20, 30, 40};
      exp_res_off = '{5, 6, 7, 8}; exp_idx_q = '{0, 1, 2, 3};
      exp_done_off = 8; exp_query = 32'd7; exp_busy = 9;
      run_req(32'd7, 6'd0, 7'd4, 64'd0, 3, 6'd2, 32'hAA, 32'hBB, -1);
      verify("collide_old");

      exp_qkv_off = '{2}; exp_q = '{32'hAA}; exp_val_q = '{32'hBB};
      exp_res_off = '{5}; exp_idx_q = '{2};
      exp_done_off = 5; exp_query = 32'd8; exp_busy = 6;
      run_req(32'd8, 6'd2, 7'd1, 64'd0, -1, 6'd0, 0, 0, -1);
      verify("collide_new");

      start = 1'b1; start_query = 32'd9; base_addr = 6'd0; count = 7'd8;
      step();
      start = 1'b0;
      step(); step();
      check("rst_mid.pre_qkv", qkv_valid, 1);
      check("rst_mid.pre_key", key, 1);
      rst = 1'b1;
      #1;
      check_all_zero("rst_mid");
      step();
      rst = 1'b0;
      act = 0;
      repeat (20) begin
         if (result_valid || done || qkv_valid || busy) act++;
         step();
      end
      check("rst_mid.quiet", act, 0);

      exp_qkv_off = '{2, 3}; exp_q = '{5, 6}; exp_val_q = '{50, 60};
      exp_res_off = '{5, 6}; exp_idx_q = '{4, 5};
      exp_done_off = 6; exp_query = 32'h33; exp_busy = 7;
      run_req(32'h33, 6'd4, 7'd2, 64'd0, -1, 6'd0, 0, 0, -1);
      verify("after_rst");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
